// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// in_ready depends only on registered state and rst, so upstream sees no combinational path from out_ready.
module pipe_skid_stage #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] main;
  logic [WIDTH-1:0] skid;
  logic             acc;
  logic             emit;

  assign out_data  = main;
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO) & ~rst;
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    count = 2'd0;
    case (state)
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
      main  <= RESET_VAL;
      skid  <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && emit) begin
            main <= in_data;
          end else if (acc) begin
            skid  <= in_data;
            state <= TWO;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // The skid entry moves forward so main always holds the oldest beat.
          if (emit) begin
            main  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and random stimulus for pipe_skid_stage; a queue scoreboard checks in-order delivery.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [1:0]  count;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_data8;
  logic [1:0]  count8;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(64), .RESET_VAL(64'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  pipe_skid_stage #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready),
    .count(count8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Recorder: an accepted beat that is not discarded by rst/flush is expected downstream.
  always @(negedge clk) begin
    if (in_valid === 1'b1 && in_ready === 1'b1 && flush === 1'b0 && rst === 1'b0)
      exp_q.push_back(in_data);
  end

  always @(posedge clk) begin
    if (rst === 1'b1 || flush === 1'b1) exp_q.delete();
  end

  // Monitor: compares every emitted beat and checks output stability under back-pressure.
  logic        hold_prev = 1'b0;
  logic [63:0] data_prev;
  always @(negedge clk) begin
    if (hold_prev) begin
      check("stable_valid", {63'b0, out_valid}, 64'd1);
      check("stable_data", out_data, data_prev);
    end
    hold_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0) && (flush === 1'b0);
    data_prev = out_data;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pop_empty", out_data, 64'hx);
      end else begin
        check("emit_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int accepted;
    int cycles;
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_valid", {63'b0, out_valid}, 64'd0);
      check("rst_count", {62'b0, count}, 64'd0);
      check("rst_in_ready", {63'b0, in_ready}, 64'd0);
      check("rst_data", out_data, 64'h0);
      check("rst_data8", {56'b0, out_data8}, 64'h5A);
    end
    rst = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    #1;
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 1'b1);
      step();
      check("stream_data", out_data, 64'(i));
      check("stream_count", {62'b0, count}, 64'd1);
      check("stream_in_ready", {63'b0, in_ready}, 64'd1);
    end
    drive(1'b0, 64'h0, 1'b1);
    step();
    check("stream_drain", {62'b0, count}, 64'd0);

    // Back-pressure
    drive(1'b1, 64'hA, 1'b0); step();
    check("bp_count1", {62'b0, count}, 64'd1);
    check("bp_data1", out_data, 64'hA);
    drive(1'b1, 64'hB, 1'b0); step();
    check("bp_count2", {62'b0, count}, 64'd2);
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    drive(1'b1, 64'hC, 1'b0); step();
    check("bp_hold_count", {62'b0, count}, 64'd2);
    check("bp_hold_data", out_data, 64'hA);
    out_ready = 1'b1; #1;
    check("bp_no_comb_path", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b0; #1;
    check("bp_no_comb_path0", {63'b0, in_ready}, 64'd0);
    drive(1'b1, 64'hC, 1'b1); step();
    check("bp_after_emit_data", out_data, 64'hB);
    check("bp_after_emit_ready", {63'b0, in_ready}, 64'd1);
    drive(1'b1, 64'hC, 1'b1); step();
    check("bp_c_data", out_data, 64'hC);
    drive(1'b0, 64'h0, 1'b1); step();
    check("bp_drain", {62'b0, count}, 64'd0);

    // Flush while full; the in-flight 0xC must be discarded
    drive(1'b1, 64'hA, 1'b0); step();
    drive(1'b1, 64'hB, 1'b0); step();
    check("fl_count2", {62'b0, count}, 64'd2);
    flush = 1'b1;
    drive(1'b1, 64'hC, 1'b0); step();
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
    check("fl_valid", {63'b0, out_valid}, 64'd0);
    check("fl_count", {62'b0, count}, 64'd0);
    check("fl_data", out_data, 64'h0);
    check("fl_data8", {56'b0, out_data8}, 64'h5A);
    step();
    check("fl_no_c", {63'b0, out_valid}, 64'd0);

    // Flush in ONE with emit and accept: emit delivered, accepted beat dropped
    drive(1'b1, 64'h11, 1'b0); step();
    flush = 1'b1;
    drive(1'b1, 64'hD, 1'b1); step();
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    check("fl1_count", {62'b0, count}, 64'd0);

    // Simultaneous rst and flush
    drive(1'b1, 64'h22, 1'b0); step();
    rst = 1'b1; flush = 1'b1;
    drive(1'b0, 64'h0, 1'b0); step();
    rst = 1'b0; flush = 1'b0;
    check("rstfl_count", {62'b0, count}, 64'd0);
    check("rstfl_data", out_data, 64'h0);
    check("rstfl_data8", {56'b0, out_data8}, 64'h5A);

    // Mid-operation rst at count=1
    drive(1'b1, 64'hE, 1'b0); step();
    check("mid_count1", {62'b0, count}, 64'd1);
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b1); step();
    rst = 1'b0;
    check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_data", out_data, 64'h0);
    check("mid_rst_data8", {56'b0, out_data8}, 64'h5A);

    // Random valid/ready
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      #1;
      if (in_valid && in_ready) accepted++;
      step();
      cycles++;
    end
    check("rand_accepted", 64'(accepted), 64'd1000);
    drive(1'b0, 64'h0, 1'b1);
    cycles = 0;
    while (count != 2'd0 && cycles < 10) begin
      step();
      cycles++;
    end
    check("rand_drain_count", {62'b0, count}, 64'd0);
    step();
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
